mem_dma: RTL and testbench

Block-copy initiator for the 8-bit memory system: on a start pulse it copies `len` consecutive words from a source address to a destination address. It drives the RAM's clocked `en`/`memwrite`/`adr`/`writedata` port and consumes its registered `memdata` output, which has one-cycle read latency. It sits beside the CPU as a second bus master; arbitration is outside this block. It refuses to touch the memory-mapped IO window, top two address bits = 2'b11.

---
 rtl/mem_dma_if.sv | 23 ++
 rtl/mem_dma.sv | 123 ++++++++++++
 tb/tb_mem_dma.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mem_dma_if.sv
// rtl/mem_dma_if.sv - RAM port bundle between the block-copy engine and the memory
// Purpose: groups the clocked RAM port (enable, write strobe, address, write data)
//          and the registered read data returned by the RAM.
// Ports (signals):
//   en     RAM enable, driven by the master
//   write  write strobe, driven by the master
//   adr    RAM address, driven by the master
//   wdata  write data, driven by the master
//   rdata  registered read data, driven by the RAM (valid the cycle after a read)
// Modports: master (copy engine side), slave (RAM side).
interface mem_dma_if #(
  parameter int WIDTH         = 8,
  parameter int RAM_ADDR_BITS = 8
);
  logic                     en;
  logic                     write;
  logic [RAM_ADDR_BITS-1:0] adr;
  logic [WIDTH-1:0]         wdata;
  logic [WIDTH-1:0]         rdata;

  modport master (output en, output write, output adr, output wdata, input rdata);
  modport slave  (input en, input write, input adr, input wdata, output rdata);
endinterface

// File: rtl/mem_dma.sv
// rtl/mem_dma.sv - block-copy bus master for the 8-bit memory system
// Purpose: on an accepted start, copies len words from src to dst, one read and
//          one write per word (2 cycles/word), aborting with err if either
//          address falls in the memory-mapped IO window (top two bits = 2'b11).
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low reset
//   start  request pulse, only sampled in IDLE
//   src    first source address, captured on accepted start
//   dst    first destination address, captured on accepted start
//   len    word count, captured on accepted start (0 = no memory access)
//   busy   high while reading or writing
//   done   one-cycle pulse when a transfer finishes or aborts
//   err    last transfer aborted on the IO window; cleared by the next start
//   mem    RAM port (master modport)
module mem_dma #(
  parameter int WIDTH         = 8,
  parameter int RAM_ADDR_BITS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [RAM_ADDR_BITS-1:0] src,
  input  logic [RAM_ADDR_BITS-1:0] dst,
  input  logic [RAM_ADDR_BITS-1:0] len,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  mem_dma_if.master                mem
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  localparam logic [RAM_ADDR_BITS-1:0] ADR_ONE = {{(RAM_ADDR_BITS-1){1'b0}}, 1'b1};

  state_t                   state;
  state_t                   state_next;
  logic [RAM_ADDR_BITS-1:0] sa;
  logic [RAM_ADDR_BITS-1:0] da;
  logic [RAM_ADDR_BITS-1:0] cnt;
  logic                     err_q;

  function automatic logic in_io(input logic [RAM_ADDR_BITS-1:0] a);
    return a[RAM_ADDR_BITS-1:RAM_ADDR_BITS-2] == 2'b11;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sa    <= '0;
      da    <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= src;
            da    <= dst;
            cnt   <= len;
            err_q <= 1'b0;
          end
        end
        RD: begin
          if (in_io(sa)) err_q <= 1'b1;
        end
        WR: begin
          // The read word is simply dropped on a destination abort.
          if (in_io(da)) begin
            err_q <= 1'b1;
          end else begin
            sa  <= sa + ADR_ONE;
            da  <= da + ADR_ONE;
            cnt <= cnt - ADR_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    mem.en     = 1'b0;
    mem.write  = 1'b0;
    mem.adr    = '0;
    mem.wdata  = '0;
    case (state)
      IDLE: begin
        if (start) state_next = (len == '0) ? DONE : RD;
      end
      RD: begin
        if (in_io(sa)) begin
          state_next = DONE;
        end else begin
          mem.en     = 1'b1;
          mem.adr    = sa;
          state_next = WR;
        end
      end
      WR: begin
        if (in_io(da)) begin
          state_next = DONE;
        end else begin
          mem.en     = 1'b1;
          mem.write  = 1'b1;
          mem.adr    = da;
          // RAM read data from the previous cycle flows straight to the write port.
          mem.wdata  = mem.rdata;
          state_next = (cnt == ADR_ONE) ? DONE : RD;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == RD) || (state == WR);
  assign done = (state == DONE);
  assign err  = err_q;

endmodule

// File: tb/tb_mem_dma.sv
// tb/tb_mem_dma.sv - self-checking bench for mem_dma with a behavioural RAM and copy model
module tb_mem_dma;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] src, dst, len;
  logic       busy, done, err;

  logic       pl_we;
  logic [7:0] pl_adr, pl_data;
  logic [7:0] ram [256];
  logic [7:0] exp_mem [256];
  logic [8:0] exp_q [$];

  int n_checks = 0;
  int n_err    = 0;

  mem_dma_if #(.WIDTH(8), .RAM_ADDR_BITS(8)) bus ();

  mem_dma #(.WIDTH(8), .RAM_ADDR_BITS(8)) dut (
    .clk   (clk),
    .reset (rst_n),
    .start (start),
    .src   (src),
    .dst   (dst),
    .len   (len),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .mem   (bus)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with registered read data; preload port used only while idle.
  always @(posedge clk) begin
    if (pl_we) ram[pl_adr] <= pl_data;
    else if (bus.en) begin
      if (bus.write) ram[bus.adr] <= bus.wdata;
      else           bus.rdata    <= ram[bus.adr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    pl_we = 1'b1; pl_adr = a; pl_data = d;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  task automatic check_mem(input string tag);
    int bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== exp_mem[i]) bad++;
    check(tag, bad, 0);
  endtask

  // Runs one copy. inj: cycle in which a spurious start with alt_src is pulsed (0 = none).
  // rst_c: cycle in which reset is asserted (0 = none).
  task automatic run_copy(input string tag, input logic [7:0] s, input logic [7:0] d,
                          input logic [7:0] l, input int inj, input logic [7:0] alt_src,
                          input int rst_c);
    int         exp_done;
    logic       exp_err;
    int         idx = 0;
    int         ndone = 0;
    int         dcyc = -1;
    int         end_c;
    logic [7:0] sk, dk;

    // Reference: word-by-word ascending copy with IO-window abort.
    for (int i = 0; i < 256; i++) exp_mem[i] = ram[i];
    exp_q.delete();
    exp_err  = 1'b0;
    exp_done = 2 * int'(l) + 1;
    for (int k = 0; k < int'(l); k++) begin
      sk = s + 8'(k);
      dk = d + 8'(k);
      if (sk[7:6] == 2'b11) begin exp_err = 1'b1; exp_done = 2 * k + 2; break; end
      exp_q.push_back({1'b0, sk});
      if (dk[7:6] == 2'b11) begin exp_err = 1'b1; exp_done = 2 * k + 3; break; end
      exp_q.push_back({1'b1, dk});
      if (rst_c == 0 || 2 * k + 2 < rst_c) exp_mem[dk] = exp_mem[sk];
    end

    src = s; dst = d; len = l; start = 1'b1;
    end_c = (rst_c != 0) ? rst_c : exp_done + 2;
    for (int c = 1; c <= end_c; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        start = 1'b0;
        check({tag, " err_clr"}, err, 1'b0);
        check({tag, " busy1"}, busy, l != 8'd0);
      end
      if (rst_c != 0 && c == rst_c) begin
        rst_n = 1'b0;
        #1;
        check({tag, " rst_outs"}, {busy, done, err, bus.en, bus.write, bus.adr}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_mem({tag, " mem"});
        return;
      end
      if (bus.en) begin
        if (idx < exp_q.size()) check({tag, " op"}, {bus.write, bus.adr}, exp_q[idx]);
        else                    check({tag, " extra_op"}, {bus.write, bus.adr}, 9'h1ff);
        idx++;
      end
      if (done) begin ndone++; dcyc = c; end
      if (inj != 0 && c == inj)     begin start = 1'b1; src = alt_src; end
      if (inj != 0 && c == inj + 1) start = 1'b0;
    end
    check({tag, " ops"}, idx, exp_q.size());
    check({tag, " ndone"}, ndone, 1);
    check({tag, " done_cyc"}, dcyc, exp_done);
    check({tag, " err"}, err, exp_err);
    check({tag, " idle"}, busy, 1'b0);
    check_mem({tag, " mem"});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; src = '0; dst = '0; len = '0;
    pl_we = 1'b0; pl_adr = '0; pl_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", {busy, done, err, bus.en, bus.write, bus.adr, bus.wdata}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));

    poke(8'h10, 8'hA1); poke(8'h11, 8'hB2); poke(8'h12, 8'hC3);
    run_copy("basic", 8'h10, 8'h20, 8'd3, 0, 8'h00, 0);
    check("basic_20", ram[8'h20], 8'hA1);
    check("basic_22", ram[8'h22], 8'hC3);

    run_copy("len0", 8'h05, 8'h06, 8'd0, 0, 8'h00, 0);
    run_copy("src_io", 8'hBE, 8'h40, 8'd4, 0, 8'h00, 0);
    run_copy("dst_io", 8'h30, 8'hFF, 8'd1, 0, 8'h00, 0);
    run_copy("after_err", 8'h50, 8'h60, 8'd2, 0, 8'h00, 0);
    run_copy("ign_start", 8'h10, 8'h70, 8'd3, 2, 8'h80, 0);
    run_copy("mid_rst", 8'h10, 8'h90, 8'd3, 0, 8'h00, 4);
    run_copy("post_rst", 8'h11, 8'hA0, 8'd3, 0, 8'h00, 0);

    for (int t = 0; t < 30; t++) begin
      logic [7:0] rs, rd, rl;
      rs = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 8'hB8)) : 8'($urandom);
      rd = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 8'hB8)) : 8'($urandom);
      rl = 8'($urandom_range(0, 10));
      run_copy("rand", rs, rd, rl, 0, 8'h00, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
